// File: rtl/pipe_dest_tracker.sv
// Producer side of the decode-stage hazard check: tracks destination/live records
// through EX/MEM/WB slots, inserts bubbles on stall/flush, and keeps stall statistics.
module pipe_dest_tracker #(
    parameter int REG_BITS  = 3,
    parameter int MAX_STALL = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [REG_BITS-1:0] id_wr_reg,
    input  logic                id_reg_write,
    input  logic                id_valid,
    input  logic                send_nop,
    input  logic                flush,
    output logic [REG_BITS-1:0] execute,
    output logic [REG_BITS-1:0] memory,
    output logic [REG_BITS-1:0] writeback,
    output logic                ex_live,
    output logic                mem_live,
    output logic                wb_live,
    output logic                fd_en,
    output logic [15:0]         stall_total,
    output logic                stall_overrun
);

    localparam int CNT_W = $clog2(MAX_STALL + 2);
    localparam logic [CNT_W-1:0] RUN_SAT   = CNT_W'(MAX_STALL + 1);
    localparam logic [CNT_W-1:0] RUN_LIMIT = CNT_W'(MAX_STALL);

    typedef struct packed {
        logic [REG_BITS-1:0] dst;
        logic                live;
    } slot_t;

    localparam slot_t BUBBLE = '{dst: '0, live: 1'b0};

    slot_t            ex_slot;
    slot_t            mem_slot;
    slot_t            wb_slot;
    slot_t            ex_next;
    logic [CNT_W-1:0] run_cnt;
    logic             stall;
    logic             adv_stall;

    // Flush wins over stall: a squashed decode slot is never counted as a stall.
    assign stall     = ~send_nop & ~flush;
    assign adv_stall = en & stall;
    assign fd_en     = en & (send_nop | flush);

    always_comb begin
        ex_next = BUBBLE;
        if (!flush && !stall) begin
            ex_next.dst  = id_wr_reg;
            ex_next.live = id_valid & id_reg_write;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_slot  <= BUBBLE;
            mem_slot <= BUBBLE;
            wb_slot  <= BUBBLE;
        end else if (en) begin
            ex_slot  <= ex_next;
            mem_slot <= ex_slot;
            wb_slot  <= mem_slot;
        end
    end

    // run_cnt saturates one past the limit so an overrun run stays distinguishable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt       <= '0;
            stall_overrun <= 1'b0;
            stall_total   <= '0;
        end else if (en) begin
            if (stall) begin
                if (run_cnt != RUN_SAT) begin
                    run_cnt <= run_cnt + 1'b1;
                end
                if (run_cnt == RUN_LIMIT) begin
                    stall_overrun <= 1'b1;
                end
                if (stall_total != 16'hFFFF) begin
                    stall_total <= stall_total + 16'd1;
                end
            end else begin
                run_cnt <= '0;
            end
        end
    end

    assign execute   = ex_slot.dst;
    assign ex_live   = ex_slot.live;
    assign memory    = mem_slot.dst;
    assign mem_live  = mem_slot.live;
    assign writeback = wb_slot.dst;
    assign wb_live   = wb_slot.live;

endmodule

// File: tb/tb_pipe_dest_tracker.sv
// Directed table-driven bench for pipe_dest_tracker plus reset and saturation sequences.
module tb_pipe_dest_tracker;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [2:0]  id_wr_reg;
    logic        id_reg_write;
    logic        id_valid;
    logic        send_nop;
    logic        flush;
    logic [2:0]  execute;
    logic [2:0]  memory;
    logic [2:0]  writeback;
    logic        ex_live;
    logic        mem_live;
    logic        wb_live;
    logic        fd_en;
    logic [15:0] stall_total;
    logic        stall_overrun;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_dest_tracker #(.REG_BITS(3), .MAX_STALL(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .id_wr_reg    (id_wr_reg),
        .id_reg_write (id_reg_write),
        .id_valid     (id_valid),
        .send_nop     (send_nop),
        .flush        (flush),
        .execute      (execute),
        .memory       (memory),
        .writeback    (writeback),
        .ex_live      (ex_live),
        .mem_live     (mem_live),
        .wb_live      (wb_live),
        .fd_en        (fd_en),
        .stall_total  (stall_total),
        .stall_overrun(stall_overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        en;
        logic [2:0]  wr;
        logic        rw;
        logic        vld;
        logic        sn;
        logic        fl;
        logic        fd;
        logic [2:0]  ex;
        logic        exl;
        logic [2:0]  mem;
        logic        meml;
        logic [2:0]  wb;
        logic        wbl;
        logic [15:0] tot;
        logic        ov;
    } vec_t;

    localparam int NV = 19;
    vec_t vt[NV];

    function automatic vec_t mk(int e, int wr, int rw, int vld, int sn, int fl, int fd,
                                int ex, int exl, int mem, int meml, int wb, int wbl,
                                int tot, int ov);
        vec_t v;
        v.en = e[0];    v.wr = wr[2:0];   v.rw = rw[0];     v.vld = vld[0];
        v.sn = sn[0];   v.fl = fl[0];     v.fd = fd[0];
        v.ex = ex[2:0]; v.exl = exl[0];   v.mem = mem[2:0]; v.meml = meml[0];
        v.wb = wb[2:0]; v.wbl = wbl[0];   v.tot = tot[15:0]; v.ov = ov[0];
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_outs(input string tag, input vec_t v);
        check({tag, " execute"},       32'(execute),       32'(v.ex));
        check({tag, " ex_live"},       32'(ex_live),       32'(v.exl));
        check({tag, " memory"},        32'(memory),        32'(v.mem));
        check({tag, " mem_live"},      32'(mem_live),      32'(v.meml));
        check({tag, " writeback"},     32'(writeback),     32'(v.wb));
        check({tag, " wb_live"},       32'(wb_live),       32'(v.wbl));
        check({tag, " stall_total"},   32'(stall_total),   32'(v.tot));
        check({tag, " stall_overrun"}, 32'(stall_overrun), 32'(v.ov));
    endtask

    task automatic drive(input logic e, input logic [2:0] wr, input logic rw, input logic vld,
                         input logic sn, input logic fl);
        en = e; id_wr_reg = wr; id_reg_write = rw; id_valid = vld; send_nop = sn; flush = fl;
    endtask

    initial begin
        vec_t zero_v;
        int   stalls;
        int   run;
        logic [15:0] exp_tot;

        //          en wr rw vl sn fl fd  ex l  mem l  wb l  tot ov
        vt[0]  = mk(1, 3, 1, 1, 1, 0, 1,  3, 1, 0, 0, 0, 0, 0, 0);   // flow r3
        vt[1]  = mk(1, 5, 1, 1, 1, 0, 1,  5, 1, 3, 1, 0, 0, 0, 0);   // flow r5
        vt[2]  = mk(1, 4, 0, 1, 1, 0, 1,  4, 0, 5, 1, 3, 1, 0, 0);   // store
        vt[3]  = mk(1, 2, 1, 1, 1, 0, 1,  2, 1, 4, 0, 5, 1, 0, 0);   // producer r2
        vt[4]  = mk(1, 7, 1, 1, 0, 0, 0,  0, 0, 2, 1, 4, 0, 1, 0);   // stall 1
        vt[5]  = mk(1, 7, 1, 1, 0, 0, 0,  0, 0, 0, 0, 2, 1, 2, 0);   // stall 2
        vt[6]  = mk(1, 7, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 3, 0);   // stall 3
        vt[7]  = mk(1, 7, 1, 1, 1, 0, 1,  7, 1, 0, 0, 0, 0, 3, 0);   // release
        vt[8]  = mk(1, 6, 1, 1, 0, 0, 0,  0, 0, 7, 1, 0, 0, 4, 0);   // run 1
        vt[9]  = mk(1, 6, 1, 1, 0, 0, 0,  0, 0, 0, 0, 7, 1, 5, 0);   // run 2
        vt[10] = mk(1, 6, 1, 1, 0, 1, 1,  0, 0, 0, 0, 0, 0, 5, 0);   // flush+stall
        vt[11] = mk(1, 1, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 6, 0);   // run 1
        vt[12] = mk(1, 1, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 7, 0);   // run 2
        vt[13] = mk(1, 1, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 8, 0);   // run 3, legal
        vt[14] = mk(0, 1, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 8, 0);   // en=0 hold
        vt[15] = mk(1, 1, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 9, 1);   // 4th stall
        vt[16] = mk(1, 1, 1, 1, 1, 0, 1,  1, 1, 0, 0, 0, 0, 9, 1);   // sticky
        vt[17] = mk(0, 5, 1, 1, 1, 1, 0,  1, 1, 0, 0, 0, 0, 9, 1);   // en=0 freeze
        vt[18] = mk(1, 2, 1, 0, 1, 0, 1,  2, 0, 1, 1, 0, 0, 9, 1);   // invalid instr

        zero_v = mk(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Power-on reset.
        rst_n = 1'b0;
        drive(1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        #2;
        check_outs("por", zero_v);
        check("por fd_en", 32'(fd_en), 32'd1);
        #6 rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(vt[i].en, vt[i].wr, vt[i].rw, vt[i].vld, vt[i].sn, vt[i].fl);
            #1;
            check($sformatf("v%0d fd_en", i), 32'(fd_en), 32'(vt[i].fd));
            @(posedge clk);
            #1;
            check_outs($sformatf("v%0d", i), vt[i]);
        end

        // Asynchronous reset mid-operation with nonzero slots and a set overrun flag.
        drive(1'b1, 3'd6, 1'b1, 1'b1, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_outs("arst", zero_v);
        check("arst fd_en flush", 32'(fd_en), 32'd1);
        drive(1'b1, 3'd6, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        check("arst fd_en stall", 32'(fd_en), 32'd0);
        @(posedge clk);
        #1;
        check("arst held total", 32'(stall_total), 32'd0);
        check("arst held execute", 32'(execute), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Saturation: 65540 stalls, one non-stall cycle after every 3 stalls.
        stalls  = 0;
        run     = 0;
        exp_tot = 16'd0;
        while (stalls < 65540) begin
            if (run == 3) begin
                drive(1'b1, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0);
                run = 0;
            end else begin
                drive(1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
                run++;
                stalls++;
                if (exp_tot != 16'hFFFF) exp_tot = exp_tot + 16'd1;
            end
            @(posedge clk);
            #1;
            if (stalls == 65535 && run == 3) begin
                check("sat reach", 32'(stall_total), 32'(exp_tot));
            end
        end
        check("sat total", 32'(stall_total), 32'hFFFF);
        check("sat total model", 32'(stall_total), 32'(exp_tot));
        check("sat no overrun", 32'(stall_overrun), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
